// File: rtl/fx_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fx_convert_pipe
// Description : Pipelined fixed-point format converter with rounding,
//               wrap/saturate overflow handling and an overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fx_convert_pipe #(
  parameter int IN_W     = 15,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int RND_MODE = 0,
  parameter int OVF_MODE = 1,
  parameter int LATENCY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic             clr_cnt,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic [15:0]      o_ovf_cnt
);

  localparam int SHIFT = OUT_FRAC - IN_FRAC;
  // Wide enough for a 32-bit input shifted left by 31 plus headroom, so
  // neither the shift nor the rounding increment can wrap.
  localparam int EXT_W = 72;
  localparam logic signed [EXT_W-1:0] OUT_MAX = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = -(EXT_W'(1) <<< (OUT_W - 1));

  logic signed [EXT_W-1:0] data_ext;
  logic signed [EXT_W-1:0] scaled;
  logic                    conv_ovf;
  logic [OUT_W-1:0]        conv_data;

  assign data_ext = {{(EXT_W - IN_W){i_data[IN_W-1]}}, i_data};

  generate
    if (SHIFT >= 0) begin : g_upscale
      assign scaled = data_ext <<< SHIFT;
    end else begin : g_downscale
      localparam int DROP = -SHIFT;
      localparam logic [31:0] HALF = 32'(1) << (DROP - 1);

      logic signed [EXT_W-1:0] floor_val;
      logic [31:0]             rem;
      logic                    round_up;

      // Arithmetic shift floors toward -inf; the dropped bits are then a
      // non-negative remainder that drives the rounding decision.
      assign floor_val = data_ext >>> DROP;
      assign rem       = 32'(data_ext[DROP-1:0]);

      always_comb begin
        round_up = 1'b0;
        case (RND_MODE)
          1:       round_up = (rem >= HALF);
          2:       round_up = (rem > HALF) || ((rem == HALF) && floor_val[0]);
          default: round_up = 1'b0;
        endcase
      end

      assign scaled = floor_val + EXT_W'(round_up);
    end
  endgenerate

  always_comb begin
    conv_ovf  = (scaled > OUT_MAX) || (scaled < OUT_MIN);
    conv_data = scaled[OUT_W-1:0];
    if (conv_ovf && (OVF_MODE == 1)) begin
      conv_data = scaled[EXT_W-1] ? OUT_MIN[OUT_W-1:0] : OUT_MAX[OUT_W-1:0];
    end
  end

  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            ovf_q, ovf_d;
  logic [LATENCY-1:0][OUT_W-1:0] data_q, data_d;
  logic [15:0]                   ovf_cnt_q, ovf_cnt_d;

  // Payload registers only load behind a valid sample so bubbles leave the
  // last valid result parked on the outputs.
  always_comb begin
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    valid_d[0] = i_valid;
    if (i_valid) begin
      data_d[0] = conv_data;
      ovf_d[0]  = conv_ovf;
    end
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      if (valid_q[k-1]) begin
        data_d[k] = data_q[k-1];
        ovf_d[k]  = ovf_q[k-1];
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_cnt) begin
      ovf_cnt_d = 16'h0000;
    end else if (valid_q[LATENCY-1] && ovf_q[LATENCY-1] && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ovf_q     <= '0;
      data_q    <= '0;
      ovf_cnt_q <= 16'h0000;
    end else begin
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_valid   = valid_q[LATENCY-1];
  assign o_data    = data_q[LATENCY-1];
  assign o_ovf     = ovf_q[LATENCY-1];
  assign o_ovf_cnt = ovf_cnt_q;

endmodule
`default_nettype wire

// File: doc/fx_convert_pipe.md
FX_CONVERT_PIPE -- requirements
Module: fx_convert_pipe

Interface
REQ-001 Parameter IN_W, default 15: input word width, two's complement, 2..32.
REQ-002 Parameter IN_FRAC, default 8: input fraction bits, 0..IN_W-1.
REQ-003 Parameter OUT_W, default 16: output word width, two's complement, 2..32.
REQ-004 Parameter OUT_FRAC, default 8: output fraction bits, 0..OUT_W-1.
REQ-005 Parameter RND_MODE, default 0: 0 truncate toward -inf, 1 round half up, 2 round half to even.
REQ-006 Parameter OVF_MODE, default 1: 0 wrap (keep low OUT_W bits), 1 saturate to OUT_W range.
REQ-007 Parameter LATENCY, default 2: pipeline depth in cycles, 1..8.
REQ-008 Ports: clk in 1: single clock, all state updates on rising edge.
REQ-009 rst in 1: reset, synchronous and active-high, single clock domain.
REQ-010 i_valid in 1: input sample qualifier.
REQ-011 i_data in IN_W: input sample.
REQ-012 clr_cnt in 1: synchronous clear of overflow counter.
REQ-013 o_valid out 1: output sample qualifier.
REQ-014 o_data out OUT_W: converted sample.
REQ-015 o_ovf out 1: overflow occurred on the sample now on o_data.
REQ-016 o_ovf_cnt out 16: count of overflowed valid samples.

Function
REQ-017 Scale shift S = OUT_FRAC - IN_FRAC; S >= 0 appends S zero LSBs, no rounding.
REQ-018 S < 0 drops D = -S LSBs; the rounding increment is computed on a full-precision intermediate one bit wider than the shifted value, so the increment never wraps.
REQ-019 RND_MODE 1 adds 1 when the dropped bits are >= half an output LSB; RND_MODE 2 does the same except that an exact half rounds to the even result.
REQ-020 Overflow: the rounded intermediate lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 With no overflow, o_data is the intermediate sign-extended or truncated to OUT_W; extra MSBs are sign copies.
REQ-022 On overflow, OVF_MODE 1 outputs 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative); OVF_MODE 0 outputs the low OUT_W bits.
REQ-023 o_ovf is asserted on overflow regardless of OVF_MODE.
REQ-024 Latency: a sample accepted with i_valid=1 at edge N appears with o_valid=1 at edge N+LATENCY.
REQ-025 Data, o_ovf and valid travel together through LATENCY registered stages; there is no backpressure and one sample is accepted per cycle.
REQ-026 When i_valid=0 a bubble propagates (o_valid=0); o_data and o_ovf then hold their last valid values.
REQ-027 o_ovf_cnt increments by 1 on each cycle with o_valid=1 and o_ovf=1, and saturates at 0xFFFF.
REQ-028 clr_cnt=1 loads 0 and takes priority over a simultaneous increment.
REQ-029 Conversion arithmetic is completed in stage 1; the remaining LATENCY-1 stages are pure delay.

Reset
REQ-030 While rst=1 at an edge, every pipeline stage valid, o_valid, o_data, o_ovf and o_ovf_cnt are set to 0.
REQ-031 Reset mid-stream discards all in-flight samples; the first valid sample presented after rst is released appears LATENCY cycles later.
REQ-032 i_valid sampled during reset is ignored.

Verification
REQ-033 Defaults (15.8 -> 16.8, LATENCY 2): i_data 0x4000 -> o_data 0xC000 two cycles later; 0x3FFF -> 0x3FFF; o_ovf=0 for both.
REQ-034 16.8 -> 8.4, RND_MODE 1, OVF_MODE 1: 0x7FFF -> 0x7F, o_ovf=1; 0x8000 -> 0x80, o_ovf=1; 0x0018 -> 0x02; 0x0028 -> 0x03.
REQ-035 Same formats, RND_MODE 2: 0x0028 -> 0x02; 0x0038 -> 0x04. RND_MODE 0: 0xFFF8 -> 0xFF.
REQ-036 16.8 -> 8.4, OVF_MODE 0: 0x1230 -> 0x23 with o_ovf=1; 300 overflowing samples -> o_ovf_cnt=300; clr_cnt pulsed together with an overflowing sample -> o_ovf_cnt=0.
REQ-037 LATENCY 4: valid pattern 1,0,1,1 reproduced on o_valid four cycles later; rst asserted after the 2nd sample -> no o_valid until a new input arrives, and all outputs read 0.
REQ-038 Force o_ovf_cnt to 0xFFFF, then present one more overflow -> o_ovf_cnt stays 0xFFFF.
